dmem_bridge: RTL and testbench

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/dmem_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_bridge.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns a single core load/store request into one transaction on
// a req/gnt + rvalid data bus. Store data is replicated across byte lanes per
// access width; load data is lane-selected and sign/zero-extended on return.
// An access that stays in REQ plus RESP for TIMEOUT_CYCLES cycles is aborted
// with an error.
//
// Optional feature: define DMEM_MISALIGN_EXC_EN so that an access whose byte
// enables are all zero is rejected in IDLE, with done_o/err_o pulsed and no
// bus request issued.
//
// Ports
//   clk_i, rst_i                 clock, async active-high reset
//   start_i, we_i, funct3_i      core request: strobe, store flag, RV32I width
//   addr_i, wdata_i, be_i        byte address, LSB-aligned store data, enables
//   busy_o, done_o, err_o        status: busy, completion pulse, error pulse
//   rdata_o                      extended load result, held between loads
//   dbus_req_o .. dbus_wdata_o   bus request channel
//   dbus_gnt_i                   bus grant
//   dbus_rvalid_i, dbus_rdata_i  bus response / write acknowledge
//
// state  | meaning
// S_IDLE | waiting for start_i; request fields hold the last access
// S_REQ  | dbus_req_o high, waiting for dbus_gnt_i
// S_RESP | granted, waiting for dbus_rvalid_i (read data or write ack)

module dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 5;
  // Counter value during the last permitted cycle; the edge that would
  // bring it to TIMEOUT_CYCLES is the one that aborts.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              misalign;
  logic              timeout;
  logic [31:0]       wdata_rep;
  logic [31:0]       rdata_shift;
  logic [31:0]       load_ext;

`ifdef DMEM_MISALIGN_EXC_EN
  assign misalign = (be_i == 4'b0000);
`else
  assign misalign = 1'b0;
`endif

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   wdata_rep = {4{wdata_i[7:0]}};
      2'b01:   wdata_rep = {2{wdata_i[15:0]}};
      default: wdata_rep = wdata_i;
    endcase
  end

  // Move the addressed lane down to bit 0, then extend by width/sign.
  assign rdata_shift = dbus_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & rdata_shift[7]}}, rdata_shift[7:0]};
      2'b01:   load_ext = {{16{~funct3_q[2] & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (misalign) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d  = S_REQ;
            cnt_d    = '0;
            we_d     = we_i;
            be_d     = be_i;
            addr_d   = {addr_i[31:2], 2'b00};
            wdata_d  = wdata_rep;
            funct3_d = funct3_i;
            off_d    = addr_i[1:0];
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (dbus_gnt_i) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // rvalid is checked first so a response on the last cycle still succeeds.
        if (dbus_rvalid_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = load_ext;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign dbus_req_o   = (state_q == S_REQ);
  assign dbus_we_o    = we_q;
  assign dbus_be_o    = be_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_addr_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];

  dmem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start_i),
    .we_i          (we_i),
    .funct3_i      (funct3_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .be_i          (be_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .rdata_o       (rdata_o),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string p);
    chk({p, "_busy"},  32'(busy_o), 0);
    chk({p, "_done"},  32'(done_o), 0);
    chk({p, "_err"},   32'(err_o), 0);
    chk({p, "_req"},   32'(dbus_req_o), 0);
    chk({p, "_we"},    32'(dbus_we_o), 0);
    chk({p, "_be"},    32'(dbus_be_o), 0);
    chk({p, "_rdata"}, rdata_o, 0);
    chk({p, "_addr"},  dbus_addr_o, 0);
    chk({p, "_wdata"}, dbus_wdata_o, 0);
  endtask

  // Called at a negedge. Drives one access, plays the bus side (stray rvalid
  // in REQ, stray gnt in RESP), and compares the completion against the
  // scoreboard entry pushed here. rv_dly < 0 means the bus never responds.
  task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int gnt_dly, input int rv_dly,
                            input logic [31:0] bus_rdata, input logic exp_err,
                            input logic [31:0] exp_rdata, input int exp_lat,
                            input logic [31:0] exp_baddr, input logic [31:0] exp_bwdata,
                            input logic hold_start);
    exp_t e;
    int req_n;
    int resp_n;
    bit seen;
    req_n  = 0;
    resp_n = 0;
    seen   = 0;
    e = '{err: exp_err, rdata: exp_rdata, lat: exp_lat, addr: exp_baddr,
          be: be, we: we, wdata: exp_bwdata};
    sb.push_back(e);
    start_i  = 1'b1;
    we_i     = we;
    funct3_i = f3;
    addr_i   = addr;
    wdata_i  = wdata;
    be_i     = be;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (hold_start) addr_i = 32'h0000_0400;
      else start_i = 1'b0;
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
      dbus_rdata_i  = 32'h5A5A_5A5A;
      if (done_o) begin
        e = sb.pop_front();
        chk({tag, "_err"},   32'(err_o), 32'(e.err));
        chk({tag, "_rdata"}, rdata_o, e.rdata);
        chk({tag, "_lat"},   32'(i), 32'(e.lat));
        chk({tag, "_idle"},  32'(busy_o), 0);
        seen = 1;
        break;
      end
      if (dbus_req_o) begin
        chk({tag, "_baddr"},  dbus_addr_o, e.addr);
        chk({tag, "_bbe"},    32'(dbus_be_o), 32'(e.be));
        chk({tag, "_bwe"},    32'(dbus_we_o), 32'(e.we));
        chk({tag, "_bwdata"}, dbus_wdata_o, e.wdata);
        dbus_gnt_i    = (req_n == gnt_dly);
        dbus_rvalid_i = !dbus_gnt_i;
        req_n++;
      end else if (busy_o) begin
        dbus_rvalid_i = (resp_n == rv_dly);
        dbus_gnt_i    = !dbus_rvalid_i;
        if (dbus_rvalid_i) dbus_rdata_i = bus_rdata;
        resp_n++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    if (!hold_start) begin
      @(negedge clk);
      chk({tag, "_pulse_done"}, 32'(done_o), 0);
      chk({tag, "_pulse_err"},  32'(err_o), 0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    start_i       = 1'b0;
    we_i          = 1'b0;
    funct3_i      = 3'b000;
    addr_i        = '0;
    wdata_i       = '0;
    be_i          = 4'b0000;
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
    dbus_rdata_i  = '0;

    @(negedge clk);
    @(negedge clk);
    check_idle_zero("rst");
    rst = 1'b0;
    @(negedge clk);

    run_access("lw", 0, 3'b010, 32'h100, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF,
               0, 32'hDEAD_BEEF, 3, 32'h100, 32'h0, 0);
    run_access("lb", 0, 3'b000, 32'h103, 32'h0, 4'h8, 0, 0, 32'h80FF_0000,
               0, 32'hFFFF_FF80, 3, 32'h100, 32'h0, 0);
    run_access("lbu", 0, 3'b100, 32'h103, 32'h0, 4'h8, 0, 0, 32'h80FF_0000,
               0, 32'h0000_0080, 3, 32'h100, 32'h0, 0);
    run_access("sh", 1, 3'b001, 32'h202, 32'h1234_ABCD, 4'hC, 4, 0, 32'h5555_5555,
               0, 32'h0000_0080, 7, 32'h200, 32'hABCD_ABCD, 0);
    run_access("lh", 0, 3'b001, 32'h102, 32'h0, 4'hC, 1, 2, 32'h8001_1234,
               0, 32'hFFFF_8001, 6, 32'h100, 32'h0, 0);
    run_access("lhu", 0, 3'b101, 32'h100, 32'h0, 4'h3, 0, 0, 32'h1234_F00D,
               0, 32'h0000_F00D, 3, 32'h100, 32'h0, 0);
    run_access("sb", 1, 3'b000, 32'h5, 32'h0000_00A5, 4'h2, 0, 1, 32'h5555_5555,
               0, 32'h0000_F00D, 4, 32'h4, 32'hA5A5_A5A5, 0);
    run_access("f3_11", 0, 3'b011, 32'h10, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D,
               0, 32'hCAFE_F00D, 3, 32'h10, 32'h0, 0);
    run_access("tmo", 0, 3'b010, 32'h20, 32'h0, 4'hF, 0, -1, 32'h0,
               1, 32'hCAFE_F00D, TO + 1, 32'h20, 32'h0, 0);
    run_access("tie", 0, 3'b010, 32'h24, 32'h0, 4'hF, 0, TO - 2, 32'h1357_2468,
               0, 32'h1357_2468, TO + 1, 32'h24, 32'h0, 0);

    // Bus handshakes while idle must not start or complete anything.
    dbus_gnt_i    = 1'b1;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    chk("stray_busy",  32'(busy_o), 0);
    chk("stray_done",  32'(done_o), 0);
    chk("stray_req",   32'(dbus_req_o), 0);
    chk("stray_rdata", rdata_o, 32'h1357_2468);
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;

    // start_i held high: ignored while busy, accepted in the done cycle.
    run_access("b2b", 0, 3'b010, 32'h300, 32'h0, 4'hF, 0, 0, 32'h0BAD_F00D,
               0, 32'h0BAD_F00D, 3, 32'h300, 32'h0, 1);
    @(negedge clk);
    start_i = 1'b0;
    chk("b2b_busy", 32'(busy_o), 1);
    chk("b2b_req",  32'(dbus_req_o), 1);
    chk("b2b_addr", dbus_addr_o, 32'h400);
    dbus_gnt_i = 1'b1;
    @(negedge clk);
    dbus_gnt_i    = 1'b0;
    chk("b2b_resp", 32'(dbus_req_o), 0);
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'h600D_CAFE;
    @(negedge clk);
    dbus_rvalid_i = 1'b0;
    chk("b2b_done",  32'(done_o), 1);
    chk("b2b_err",   32'(err_o), 0);
    chk("b2b_rdata", rdata_o, 32'h600D_CAFE);
    @(negedge clk);
    chk("b2b_pulse", 32'(done_o), 0);

`ifdef DMEM_MISALIGN_EXC_EN
    run_access("misal", 0, 3'b001, 32'h1, 32'h0, 4'h0, 0, 0, 32'h00AB_CD00,
               1, 32'h600D_CAFE, 1, 32'h0, 32'h0, 0);
    chk("misal_req", 32'(dbus_req_o), 0);
`else
    run_access("be0", 0, 3'b001, 32'h1, 32'h0, 4'h0, 0, 0, 32'h00AB_CD00,
               0, 32'hFFFF_ABCD, 3, 32'h0, 32'h0, 0);
`endif

    // Reset during RESP aborts silently; the late rvalid is ignored.
    start_i  = 1'b1;
    we_i     = 1'b0;
    funct3_i = 3'b010;
    addr_i   = 32'h500;
    be_i     = 4'hF;
    @(negedge clk);
    start_i    = 1'b0;
    chk("mrst_req", 32'(dbus_req_o), 1);
    dbus_gnt_i = 1'b1;
    @(negedge clk);
    dbus_gnt_i = 1'b0;
    chk("mrst_resp", 32'(busy_o), 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero("mrst");
    rst           = 1'b0;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'h1234_5678;
    @(negedge clk);
    dbus_rvalid_i = 1'b0;
    chk("late_rv_done",  32'(done_o), 0);
    chk("late_rv_busy",  32'(busy_o), 0);
    @(negedge clk);
    chk("late_rv_done2", 32'(done_o), 0);
    chk("late_rv_err",   32'(err_o), 0);
    chk("late_rv_rdata", rdata_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
